// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter merging N_REQ byte streams into one UART TX
//            FIFO, framing each message with a header byte 8'hA0 | id.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_EN,
  output logic [7:0]                 fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       len_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   r_last_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_len_err;

  logic [ID_W-1:0]   w_start;
  logic [ID_W-1:0]   w_winner;
  logic [7:0]        w_grant_byte;
  logic [7:0]        w_sel_data;
  logic              w_sel_last;
  logic              w_at_max;
  logic              w_xfer;

  assign w_start      = (r_last_id == ID_W'(N_REQ - 1)) ? '0 : r_last_id + 1'b1;
  assign w_grant_byte = {{(8 - ID_W){1'b0}}, r_grant};
  assign w_sel_data   = req_data[{r_grant, 3'b000} +: 8];
  assign w_sel_last   = req_last[r_grant];
  assign w_at_max     = (r_cnt == CNT_W'(MAX_LEN - 1));

  // Second pass overrides the first, so a requester at/after w_start beats a wrapped one.
  always_comb begin
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_winner = ID_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= w_start)) w_winner = ID_W'(i);
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_EN   = 1'b0;
    fifo_data_in = 8'h00;
    w_xfer       = 1'b0;
    case (r_state)
      S_HEADER: begin
        if (!fifo_full) begin
          fifo_wr_EN   = 1'b1;
          fifo_data_in = 8'hA0 | w_grant_byte;
        end
      end
      S_PAYLOAD: begin
        req_ready[r_grant] = !fifo_full;
        w_xfer             = req_valid[r_grant] && !fifo_full;
        if (w_xfer) begin
          fifo_wr_EN   = 1'b1;
          fifo_data_in = w_sel_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last_id <= ID_W'(N_REQ - 1);
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_winner;
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!fifo_full) begin
            r_cnt   <= '0;
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            // The MAX_LEN-th byte closes the message even without req_last.
            if (w_sel_last || w_at_max) begin
              r_state   <= S_IDLE;
              r_last_id <= r_grant;
              r_len_err <= !w_sel_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);
  assign len_err  = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter; requester byte sources and
//            an expected FIFO write queue checked every cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int ML = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_EN;
  logic [7:0]       fifo_data_in;
  logic [1:0]       grant_id;
  logic             busy;
  logic             len_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(ML)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_EN   (fifo_wr_EN),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .len_err      (len_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  exp_q[$];
  int          wr_cyc[$];
  int          len_cyc[$];
  logic        full_q[$];
  logic [7:0]  src_data[N][64];
  logic        src_last[N][64];
  int          src_wr[N];
  int          src_rd[N];
  logic        acc[N];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input logic l);
    src_data[id][src_wr[id]] = d;
    src_last[id][src_wr[id]] = l;
    src_wr[id]++;
  endtask

  task automatic expect_msg(input int id, input logic [7:0] first, input int len);
    exp_q.push_back(8'hA0 | 8'(id));
    for (int k = 0; k < len; k++) exp_q.push_back(first + 8'(k));
  endtask

  task automatic push_seq(input int id, input logic [7:0] first, input int len, input logic end_last);
    for (int k = 0; k < len; k++) push_byte(id, first + 8'(k), end_last && (k == len - 1));
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_rd[i] < src_wr[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_data[i][src_rd[i]];
        req_last[i]       = src_last[i][src_rd[i]];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    fifo_full = (full_q.size() > 0) ? full_q.pop_front() : 1'b0;
  endtask

  // Sample on the falling edge, advance sources and inputs just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (fifo_wr_EN) begin
      chk_eq("wr_while_full", fifo_full, 0);
      if (exp_q.size() == 0) begin
        chk_eq("spurious_wr_queue", 32'(exp_q.size()), 1);
      end else begin
        chk_eq("fifo_data", fifo_data_in, exp_q.pop_front());
        wr_cyc.push_back(cyc);
      end
    end
    chk_eq("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (len_err) len_cyc.push_back(cyc);
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
    drive();
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || pending()) && k < budget) begin
      step();
      k++;
    end
    chk_eq("drain_exp", 32'(exp_q.size()), 0);
    chk_eq("drain_src", 32'(pending()), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    exp_q.delete();
    full_q.delete();
    drive();
    #1;
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_wr_en", fifo_wr_EN, 0);
    chk_eq("rst_data", fifo_data_in, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_grant", grant_id, 0);
    chk_eq("rst_len_err", len_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int c0;
    apply_reset();

    // Single requester 1 message: header latency, back-to-back writes, busy drop.
    c0 = cyc;
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    wr_cyc.delete();
    drive();
    step();
    chk_eq("busy_in_msg", busy, 1);
    run_until_done(20);
    chk_eq("busy_after_last", busy, 0);
    chk_eq("s1_wr_count", 32'(wr_cyc.size()), 4);
    if (wr_cyc.size() == 4) begin
      chk_eq("s1_hdr_latency", 32'(wr_cyc[0]), 32'(c0 + 1));
      for (int k = 1; k < 4; k++) chk_eq("s1_consecutive", 32'(wr_cyc[k]), 32'(wr_cyc[k-1] + 1));
    end

    // Fresh reset, requesters 0 and 2 alternate two messages each.
    apply_reset();
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
    push_byte(0, 8'h05, 1'b0); push_byte(0, 8'h06, 1'b1);
    push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b1);
    push_byte(2, 8'h25, 1'b0); push_byte(2, 8'h26, 1'b1);
    expect_msg(0, 8'h01, 2);
    expect_msg(2, 8'h21, 2);
    expect_msg(0, 8'h05, 2);
    expect_msg(2, 8'h25, 2);
    drive();
    run_until_done(60);

    // fifo_full toggling during a 4-byte payload from requester 1.
    c0 = cyc;
    full_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    push_seq(1, 8'h41, 4, 1'b1);
    expect_msg(1, 8'h41, 4);
    wr_cyc.delete();
    drive();
    run_until_done(40);
    chk_eq("s5_wr_count", 32'(wr_cyc.size()), 5);
    if (wr_cyc.size() == 5) begin
      chk_eq("s5_wr_cyc0", 32'(wr_cyc[0] - c0), 1);
      chk_eq("s5_wr_cyc1", 32'(wr_cyc[1] - c0), 3);
      chk_eq("s5_wr_cyc2", 32'(wr_cyc[2] - c0), 5);
      chk_eq("s5_wr_cyc4", 32'(wr_cyc[4] - c0), 7);
    end

    // Requester 3 streams 17 bytes without last: truncation after MAX_LEN.
    push_seq(3, 8'h60, ML, 1'b0);
    push_byte(3, 8'h70, 1'b0);
    push_byte(3, 8'h71, 1'b1);
    expect_msg(3, 8'h60, ML);
    expect_msg(3, 8'h70, 2);
    wr_cyc.delete();
    len_cyc.delete();
    drive();
    run_until_done(80);
    chk_eq("len_err_pulses", 32'(len_cyc.size()), 1);
    if (len_cyc.size() == 1 && wr_cyc.size() == 20) begin
      chk_eq("len_err_timing", 32'(len_cyc[0]), 32'(wr_cyc[16] + 1));
      chk_eq("regrant_gap", 32'(wr_cyc[17]), 32'(wr_cyc[16] + 2));
    end

    // Exactly MAX_LEN bytes with last on the final one: no length error.
    push_seq(2, 8'h80, ML, 1'b1);
    expect_msg(2, 8'h80, ML);
    len_cyc.delete();
    drive();
    run_until_done(60);
    chk_eq("no_len_err_at_max", 32'(len_cyc.size()), 0);

    // Header held off by three full cycles.
    c0 = cyc;
    full_q = '{1'b0, 1'b1, 1'b1, 1'b1};
    push_byte(0, 8'h77, 1'b1);
    expect_msg(0, 8'h77, 1);
    wr_cyc.delete();
    drive();
    run_until_done(20);
    if (wr_cyc.size() > 0) chk_eq("hdr_after_full", 32'(wr_cyc[0]), 32'(c0 + 4));
    else chk_eq("hdr_after_full_count", 32'(wr_cyc.size()), 2);

    // Reset in the middle of requester 1's payload, then 0 and 1 contend.
    push_seq(1, 8'h51, 4, 1'b1);
    expect_msg(1, 8'h51, 4);
    drive();
    for (int k = 0; k < 10 && exp_q.size() > 3; k++) step();
    chk_eq("pre_rst_busy", busy, 1);
    chk_eq("pre_rst_wr", fifo_wr_EN, 1);
    apply_reset();
    push_byte(0, 8'h61, 1'b1);
    push_byte(1, 8'h71, 1'b1);
    expect_msg(0, 8'h61, 1);
    expect_msg(1, 8'h71, 1);
    drive();
    run_until_done(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..16) sharing the UART TX FIFO.
REQ-002 Parameter MAX_LEN, default 16, maximum payload bytes per message (1..255).
REQ-003 clk  input  1  single clock (TX FIFO write clock).
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester byte valid.
REQ-006 req_data  input  8*N_REQ  flattened bytes; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  marks final byte of a message.
REQ-008 req_ready  output  N_REQ  per-requester byte accept.
REQ-009 fifo_full  input  1  TX FIFO full flag.
REQ-010 fifo_wr_EN  output  1  TX FIFO write enable.
REQ-011 fifo_data_in  output  8  TX FIFO write data.
REQ-012 grant_id  output  clog2(N_REQ)  currently/last granted requester.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 len_err  output  1  one-cycle pulse when a message is truncated at MAX_LEN.

Function
REQ-015 FSM states: IDLE, HEADER, PAYLOAD; state, grant_id, round-robin pointer, byte counter and len_err are registers; req_ready, fifo_wr_EN and fifo_data_in are combinational from the current state.
REQ-016 IDLE: if any req_valid bit is high, the FSM registers the round-robin winner into grant_id and moves to HEADER; no FIFO write and no req_ready occur in IDLE.
REQ-017 Round-robin: the search starts at (last served id + 1) mod N_REQ, and the lowest index at or after that start wins.
REQ-018 HEADER: when fifo_full=0, the block drives fifo_wr_EN=1 and fifo_data_in=8'hA0 | grant_id, clears the byte counter and moves to PAYLOAD.
REQ-019 HEADER with fifo_full=1: no write occurs and the FSM stays in HEADER.
REQ-020 PAYLOAD: req_ready[grant_id] = !fifo_full, and all other req_ready bits are 0.
REQ-021 A transfer occurs when req_valid[grant_id] and req_ready[grant_id] are both high; on a transfer, fifo_wr_EN=1 and fifo_data_in = req_data of the granted requester.
REQ-022 When req_valid[grant_id] is deasserted mid-message, the FSM holds the grant and waits with no timeout.
REQ-023 A transfer with req_last=1 moves the FSM to IDLE and sets the last-served pointer to grant_id.
REQ-024 The byte counter is clog2(MAX_LEN+1) bits wide and increments on each payload transfer.
REQ-025 A transfer that is the MAX_LEN-th byte with req_last=0 ends the message as if req_last=1 and sets len_err high for the following cycle only.
REQ-026 A MAX_LEN-th byte transfer with req_last=1 is a normal end, and len_err stays 0.
REQ-027 Latency: req_valid first seen in IDLE at edge t gives the header write in cycle t+1 and, with fifo_full=0, the first payload write in cycle t+2.
REQ-028 The block never asserts fifo_wr_EN while fifo_full=1.
REQ-029 A new arbitration occurs only in IDLE; after a message ends, IDLE lasts at least one cycle.
REQ-030 The block produces at most one FIFO write per cycle.

Reset
REQ-031 While rst_n=0, all registers are cleared asynchronously: state=IDLE, grant_id=0, len_err=0, byte counter=0, and the round-robin pointer is set so requester 0 has first priority.
REQ-032 While rst_n=0, the outputs are req_ready=0, fifo_wr_EN=0, fifo_data_in=8'h00 and busy=0.
REQ-033 A reset asserted mid-message abandons that message; no resumption occurs after release.

Verification
REQ-034 Requester 1 sends 8'h11, 8'h22, 8'h33 (last on 8'h33) with fifo_full=0 -> the FIFO writes 8'hA1, 8'h11, 8'h22, 8'h33 in consecutive cycles, and busy falls after the 8'h33 write.
REQ-035 After reset, requesters 0 and 2 assert simultaneously with 2-byte messages, then repeat -> order is 0, 2, 0, 2, and each header is 8'hA0 or 8'hA2 respectively.
REQ-036 fifo_full=1 for 3 cycles during HEADER -> no writes in those cycles; 8'hA0|id is written in the first cycle fifo_full=0.
REQ-037 MAX_LEN=16, requester 3 streams 17 bytes with req_last=0 -> header 8'hA3 plus 16 payload writes, a 1-cycle len_err, and byte 17 not accepted until requester 3 is granted again.
REQ-038 rst_n pulsed low while requester 1 is in PAYLOAD -> outputs go to 0 immediately, and after release a simultaneous request from requesters 0 and 1 grants 0 first.
REQ-039 fifo_full toggles 1,0,1,0 during a 4-byte payload -> writes occur only in the cycles where fifo_full=0, with bytes in order and none lost or duplicated.
